// File: rtl/round_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : round_ctrl
// Description : Round sequencer for the tug-of-war scorer. Waits a
//               pseudo-random "lights off" delay, lights the lamp, and turns
//               the first button push of the round into a single scored
//               event (winrnd) with right/tie qualifiers. A 16-bit LFSR sets
//               the delay and selects fake rounds. Stops issuing rounds once
//               the scorer reports game_over.
// Revision    : 1.0 - initial release
// ============================================================================
module round_ctrl #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          DELAY_MIN   = 64,
    parameter int          DELAY_BITS  = 6,
    parameter int          LIT_TIMEOUT = 256,
    parameter bit          FAKE_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    input  logic       game_over,
    output logic       leds_on,
    output logic       fake,
    output logic       winrnd,
    output logic       right,
    output logic       tie,
    output logic [2:0] state_dbg
);

    // Delay counter holds up to DELAY_MIN + 2^DELAY_BITS - 1; the lit
    // counter holds up to LIT_TIMEOUT.
    localparam int c_cnt_w  = $clog2(DELAY_MIN + (1 << DELAY_BITS));
    localparam int c_tcnt_w = $clog2(LIT_TIMEOUT + 1);

    localparam logic [c_cnt_w-1:0]  c_delay_min = DELAY_MIN[c_cnt_w-1:0];
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_tcnt_w-1:0] c_tcnt_init = LIT_TIMEOUT[c_tcnt_w-1:0];
    localparam logic [c_tcnt_w-1:0] c_tcnt_one  = c_tcnt_w'(1);

    // State encoding doubles as the state_dbg value.
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_wait  = 3'd1;
    localparam logic [2:0] c_st_lit   = 3'd2;
    localparam logic [2:0] c_st_score = 3'd3;
    localparam logic [2:0] c_st_hold  = 3'd4;
    localparam logic [2:0] c_st_over  = 3'd5;

    logic [2:0]          r_state;
    logic [15:0]         r_lfsr;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic                r_cap_leds;
    logic                r_leds_on;
    logic                r_fake;
    logic                r_winrnd;
    logic                r_right;
    logic                r_tie;

    logic [2:0]          w_state_nxt;
    logic [15:0]         w_lfsr_nxt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_tcnt_w-1:0] w_tcnt_nxt;
    logic                w_cap_leds_nxt;
    logic                w_leds_on_nxt;
    logic                w_fake_nxt;
    logic                w_winrnd_nxt;
    logic                w_right_nxt;
    logic                w_tie_nxt;

    logic                w_push;
    logic                w_released;
    logic [c_cnt_w-1:0]  w_cnt_load;
    logic                w_fake_pick;

    assign w_push      = pbl | pbr;
    assign w_released  = ~pbl & ~pbr;
    assign w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    // Delay and fake pick both use the LFSR value present in the IDLE exit cycle.
    assign w_cnt_load  = c_delay_min + {{(c_cnt_w - DELAY_BITS){1'b0}}, r_lfsr[DELAY_BITS-1:0]};
    assign w_fake_pick = FAKE_EN & r_lfsr[15] & r_lfsr[14];

    // Next-state and next-output decode; outputs are derived from the next state
    // so that every output port comes straight from a flop.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tcnt_nxt     = r_tcnt;
        w_cap_leds_nxt = r_cap_leds;
        w_fake_nxt     = r_fake;
        w_right_nxt    = r_right;
        w_tie_nxt      = r_tie;

        case (r_state)
            c_st_idle: begin
                if (game_over) begin
                    w_state_nxt = c_st_over;
                    w_fake_nxt  = 1'b0;
                end else if (w_released) begin
                    w_state_nxt = c_st_wait;
                    w_cnt_nxt   = w_cnt_load;
                    w_fake_nxt  = w_fake_pick;
                end
            end
            c_st_wait: begin
                // A push before the lamp is a jump-the-light and wins over expiry.
                if (w_push) begin
                    w_state_nxt    = c_st_score;
                    w_cap_leds_nxt = 1'b0;
                    w_right_nxt    = pbr & ~pbl;
                    w_tie_nxt      = pbl & pbr;
                end else if (r_cnt == c_cnt_one) begin
                    w_state_nxt = c_st_lit;
                    w_tcnt_nxt  = c_tcnt_init;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            c_st_lit: begin
                if (w_push) begin
                    w_state_nxt    = c_st_score;
                    w_cap_leds_nxt = 1'b1;
                    w_right_nxt    = pbr & ~pbl;
                    w_tie_nxt      = pbl & pbr;
                end else if (r_tcnt == c_tcnt_one) begin
                    // Abandoned round: no score, back to IDLE.
                    w_state_nxt = c_st_idle;
                    w_fake_nxt  = 1'b0;
                end else begin
                    w_tcnt_nxt = r_tcnt - c_tcnt_one;
                end
            end
            c_st_score: begin
                w_state_nxt = c_st_hold;
            end
            c_st_hold: begin
                // Waiting for both buttons up keeps a held button from scoring twice.
                if (w_released) begin
                    w_state_nxt = c_st_idle;
                    w_right_nxt = 1'b0;
                    w_tie_nxt   = 1'b0;
                    w_fake_nxt  = 1'b0;
                end
            end
            c_st_over: begin
                w_fake_nxt  = 1'b0;
                w_right_nxt = 1'b0;
                w_tie_nxt   = 1'b0;
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_fake_nxt  = 1'b0;
                w_right_nxt = 1'b0;
                w_tie_nxt   = 1'b0;
            end
        endcase

        w_winrnd_nxt  = (w_state_nxt == c_st_score);
        w_leds_on_nxt = (w_state_nxt == c_st_lit) |
                        ((w_state_nxt == c_st_score) & w_cap_leds_nxt);
    end

    // State, counters, LFSR and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_lfsr     <= SEED;
            r_cnt      <= '0;
            r_tcnt     <= '0;
            r_cap_leds <= 1'b0;
            r_leds_on  <= 1'b0;
            r_fake     <= 1'b0;
            r_winrnd   <= 1'b0;
            r_right    <= 1'b0;
            r_tie      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_cap_leds <= w_cap_leds_nxt;
            r_leds_on  <= w_leds_on_nxt;
            r_fake     <= w_fake_nxt;
            r_winrnd   <= w_winrnd_nxt;
            r_right    <= w_right_nxt;
            r_tie      <= w_tie_nxt;
        end
    end

    assign leds_on   = r_leds_on;
    assign fake      = r_fake;
    assign winrnd    = r_winrnd;
    assign right     = r_right;
    assign tie       = r_tie;
    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_round_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_round_ctrl
// Description : Scoreboard bench for round_ctrl. The driver plays rounds and
//               queues the expected scored event; a monitor pops and compares
//               whenever winrnd is seen. A second instance with fake rounds
//               disabled shares all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_ctrl;

    localparam int          DMIN   = 4;
    localparam int          DBITS  = 3;
    localparam int          LTO    = 8;
    localparam logic [15:0] SEED_V = 16'hACE1;

    localparam int K_JUMP = 0;
    localparam int K_LIT  = 1;
    localparam int K_TIE  = 2;
    localparam int K_TOUT = 3;
    localparam int K_RST  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pbl = 1'b1;
    logic       pbr = 1'b0;
    logic       game_over = 1'b0;
    logic       leds_on, fake, winrnd, right, tie;
    logic [2:0] state_dbg;
    logic       nf_leds_on, nf_fake, nf_winrnd, nf_right, nf_tie;
    logic [2:0] nf_state_dbg;

    round_ctrl #(.SEED(SEED_V), .DELAY_MIN(DMIN), .DELAY_BITS(DBITS),
                 .LIT_TIMEOUT(LTO), .FAKE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .game_over(game_over),
        .leds_on(leds_on), .fake(fake), .winrnd(winrnd), .right(right),
        .tie(tie), .state_dbg(state_dbg));

    round_ctrl #(.SEED(SEED_V), .DELAY_MIN(DMIN), .DELAY_BITS(DBITS),
                 .LIT_TIMEOUT(LTO), .FAKE_EN(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .game_over(game_over),
        .leds_on(nf_leds_on), .fake(nf_fake), .winrnd(nf_winrnd), .right(nf_right),
        .tie(nf_tie), .state_dbg(nf_state_dbg));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int saw_fake = 0;

    typedef struct {
        int   cyc;
        logic right;
        logic tie;
        logic leds;
        logic fake;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference LFSR: value the design should hold between edges.
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk) begin
        m_lfsr <= rst ? SEED_V : lfsr_step(m_lfsr);
        m_prev <= m_lfsr;
        cyc    <= cyc + 1;
    end

    task automatic check(input string name, input logic ok, input int act, input int exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every winrnd pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("winrnd_missing", 1'b0, 0, 1);
            void'(sb.pop_front());
        end
        if (winrnd === 1'b1) begin
            if (sb.size() == 0) begin
                check("winrnd_unexpected", 1'b0, 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("score_cycle", cyc == mon_e.cyc, cyc, mon_e.cyc);
                check("score_right", right === mon_e.right, int'(right), int'(mon_e.right));
                check("score_tie", tie === mon_e.tie, int'(tie), int'(mon_e.tie));
                check("score_leds", leds_on === mon_e.leds, int'(leds_on), int'(mon_e.leds));
                check("score_fake", fake === mon_e.fake, int'(fake), int'(mon_e.fake));
                check("score_state", state_dbg === 3'd3, int'(state_dbg), 3);
            end
        end
    end

    // One round from IDLE. when<0 on a jump means the last WAIT cycle.
    task automatic do_round(input int kind, input int when, input logic [1:0] btn,
                            input bit go_end, output int entry_wait);
        int   idx;
        int   w;
        int   exp_delay;
        int   bad;
        logic exp_fake;
        logic exp_r;
        logic exp_tie;
        pbl = 1'b0;
        pbr = 1'b0;
        entry_wait = 0;
        do begin
            @(negedge clk);
            entry_wait++;
        end while (state_dbg !== 3'd1 && entry_wait < 20);
        if (state_dbg !== 3'd1) begin
            check("wait_entry", 1'b0, int'(state_dbg), 1);
            return;
        end
        exp_delay = DMIN + int'(m_prev[DBITS-1:0]);
        exp_fake  = m_prev[15] & m_prev[14];
        check("fake_latch", fake === exp_fake, int'(fake), int'(exp_fake));
        check("fake_disabled", nf_fake === 1'b0, int'(nf_fake), 0);
        if (exp_fake) saw_fake++;
        exp_r   = btn[0] & ~btn[1];
        exp_tie = btn[1] & btn[0];
        idx = 0;
        if (kind == K_JUMP) begin
            w = (when < 0) ? exp_delay - 1 : when % exp_delay;
            repeat (w) @(negedge clk);
            check("jump_lamp_off", state_dbg === 3'd1 && leds_on === 1'b0,
                  int'({state_dbg, leds_on}), 2);
            {pbl, pbr} = btn;
            sb.push_back('{cyc: cyc + 1, right: exp_r, tie: exp_tie, leds: 1'b0, fake: exp_fake});
        end else begin
            while (leds_on !== 1'b1 && idx < 40) begin
                @(negedge clk);
                idx++;
            end
            check("lamp_delay", idx == exp_delay && state_dbg === 3'd2, idx, exp_delay);
            if (kind == K_TOUT) begin
                repeat (LTO - 1) @(negedge clk);
                check("lit_last", leds_on === 1'b1 && state_dbg === 3'd2, int'(state_dbg), 2);
                if (go_end) game_over = 1'b1;
                @(negedge clk);
                check("timeout_idle", leds_on === 1'b0 && state_dbg === 3'd0 && fake === 1'b0,
                      int'({state_dbg, leds_on, fake}), 0);
                return;
            end
            repeat (when) @(negedge clk);
            check("lit_before_push", leds_on === 1'b1 && state_dbg === 3'd2, int'(state_dbg), 2);
            {pbl, pbr} = btn;
            sb.push_back('{cyc: cyc + 1, right: exp_r, tie: exp_tie, leds: 1'b1, fake: exp_fake});
        end
        @(negedge clk);
        if (kind == K_RST) begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_score_outputs",
                  state_dbg === 3'd0 && winrnd === 1'b0 && leds_on === 1'b0 &&
                  fake === 1'b0 && right === 1'b0 && tie === 1'b0,
                  int'({state_dbg, winrnd, leds_on, fake, right, tie}), 0);
            check("rst_score_lfsr", dut.r_lfsr === SEED_V, int'(dut.r_lfsr), int'(SEED_V));
            rst = 1'b0;
            pbl = 1'b0;
            pbr = 1'b0;
            return;
        end
        bad = 0;
        repeat ((kind == K_TIE) ? 10 : 1) begin
            @(negedge clk);
            if (!(state_dbg === 3'd4 && winrnd === 1'b0 && leds_on === 1'b0 &&
                  right === exp_r && tie === exp_tie && fake === exp_fake)) bad++;
        end
        check("hold", bad == 0, bad, 0);
        pbl = 1'b0;
        pbr = 1'b0;
        @(negedge clk);
        check("release_idle", state_dbg === 3'd0 && right === 1'b0 && tie === 1'b0 &&
              fake === 1'b0 && leds_on === 1'b0, int'({state_dbg, right, tie, fake}), 0);
    endtask

    initial begin
        int ew;
        int bad;
        int kind;
        logic [1:0] b;
        repeat (3) @(negedge clk);
        check("reset_outputs", state_dbg === 3'd0 && leds_on === 1'b0 && fake === 1'b0 &&
              winrnd === 1'b0 && right === 1'b0 && tie === 1'b0,
              int'({state_dbg, leds_on, fake, winrnd, right, tie}), 0);
        check("reset_lfsr", dut.r_lfsr === SEED_V, int'(dut.r_lfsr), int'(SEED_V));
        rst = 1'b0;
        @(negedge clk);
        check("idle_hold_pressed", state_dbg === 3'd0 && leds_on === 1'b0, int'(state_dbg), 0);

        do_round(K_LIT, 2, 2'b01, 1'b0, ew);
        check("idle_exit", ew == 1, ew, 1);
        do_round(K_JUMP, 1, 2'b10, 1'b0, ew);
        do_round(K_TIE, 3, 2'b11, 1'b0, ew);
        do_round(K_TOUT, 0, 2'b00, 1'b0, ew);
        do_round(K_LIT, LTO - 1, 2'b10, 1'b0, ew);
        do_round(K_JUMP, -1, 2'b01, 1'b0, ew);
        do_round(K_JUMP, 0, 2'b11, 1'b0, ew);
        do_round(K_RST, 1, 2'b10, 1'b0, ew);

        for (int r = 0; r < 28; r++) begin
            kind = int'($urandom_range(0, 3));
            b    = (kind == K_TIE) ? 2'b11 : 2'($urandom_range(1, 3));
            do_round(kind, int'($urandom_range(0, LTO - 1)), b, 1'b0, ew);
        end
        check("fake_seen", saw_fake > 0, saw_fake, 1);

        do_round(K_TOUT, 0, 2'b00, 1'b1, ew);
        @(negedge clk);
        check("over_entry", state_dbg === 3'd5 && leds_on === 1'b0 && fake === 1'b0 &&
              winrnd === 1'b0 && right === 1'b0 && tie === 1'b0, int'(state_dbg), 5);
        game_over = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            {pbl, pbr} = 2'(i % 3);
            @(negedge clk);
            if (!(state_dbg === 3'd5 && leds_on === 1'b0 && fake === 1'b0 &&
                  winrnd === 1'b0 && right === 1'b0 && tie === 1'b0)) bad++;
        end
        check("over_sticky", bad == 0, bad, 0);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size() == 0, sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
